// File: rtl/csr_pkg.sv
// Shared definitions for the machine CSR file: CSR addresses, SYSTEM opcode,
// Zicsr funct3 encodings and the read-modify-write operation kind.
package csr_pkg;

    localparam logic [11:0] ADDR_TOHOST    = 12'h51E;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    typedef enum logic [1:0] {
        CSR_RW,
        CSR_RS,
        CSR_RC
    } csr_op_e;

    // The 0xCxx block holds the user-level read-only counter shadows.
    function automatic logic is_ro_addr(input logic [11:0] addr);
        return addr[11:8] == 4'hC;
    endfunction

endpackage

// File: rtl/csr_counter.sv
// CNT_WIDTH-bit free-running counter readable/writable as two XLEN halves.
// A write to either half wins over the increment in that cycle.
module csr_counter #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            wr_lo,
    input  logic            wr_hi,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] hi
);

    localparam int HI_W = CNT_WIDTH - XLEN;

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo || wr_hi) begin
            if (wr_lo) cnt_d[XLEN-1:0] = wdata;
            if (wr_hi) cnt_d[CNT_WIDTH-1:XLEN] = wdata[HI_W-1:0];
        end else if (inc) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign lo = cnt_q[XLEN-1:0];
    assign hi = XLEN'(cnt_q[CNT_WIDTH-1:XLEN]);

endmodule

// File: rtl/csr_file.sv
// Zicsr machine CSR file: tohost, mscratch and optional 64-bit cycle/instret
// counters. Returns the old value combinationally and commits on the clock edge.
module csr_file
    import csr_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              CNT_WIDTH    = 64,
    parameter bit              HAS_COUNTERS = 1'b1,
    parameter logic [XLEN-1:0] TOHOST_RST   = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            valid,
    input  logic            stall,
    input  logic            retire,
    output logic [XLEN-1:0] rd_data,
    output logic            illegal,
    output logic [XLEN-1:0] tohost,
    output logic            tohost_wr
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1_f;
    logic [11:0] addr;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign rs1_f  = inst[19:15];
    assign addr   = inst[31:20];

    logic    csr_inst, use_imm, write_intent, hit, bad, commit;
    csr_op_e op;
    logic [XLEN-1:0] src, old_val, new_val;

    always_comb begin
        csr_inst = 1'b0;
        use_imm  = 1'b0;
        op       = CSR_RW;
        if (opcode == OPC_SYSTEM) begin
            case (funct3)
                F3_CSRRW:  begin csr_inst = 1'b1; op = CSR_RW; end
                F3_CSRRS:  begin csr_inst = 1'b1; op = CSR_RS; end
                F3_CSRRC:  begin csr_inst = 1'b1; op = CSR_RC; end
                F3_CSRRWI: begin csr_inst = 1'b1; op = CSR_RW; use_imm = 1'b1; end
                F3_CSRRSI: begin csr_inst = 1'b1; op = CSR_RS; use_imm = 1'b1; end
                F3_CSRRCI: begin csr_inst = 1'b1; op = CSR_RC; use_imm = 1'b1; end
                default:   csr_inst = 1'b0;
            endcase
        end
    end

    assign src          = use_imm ? XLEN'(rs1_f) : rs1_data;
    // Set/clear with a zero source is a pure read, even for the read-only block.
    assign write_intent = (op == CSR_RW) || (rs1_f != 5'd0);

    function automatic logic [XLEN-1:0] csr_apply(input csr_op_e o,
                                                  input logic [XLEN-1:0] old,
                                                  input logic [XLEN-1:0] s);
        case (o)
            CSR_RS:  return old | s;
            CSR_RC:  return old & ~s;
            default: return s;
        endcase
    endfunction

    logic [XLEN-1:0] tohost_q, tohost_d, mscratch_q, mscratch_d;
    logic            tohost_wr_q, tohost_wr_d;
    logic [XLEN-1:0] mcycle_lo, mcycle_hi, minstret_lo, minstret_hi;

    always_comb begin
        hit     = 1'b0;
        old_val = '0;
        case (addr)
            ADDR_TOHOST:                   begin hit = 1'b1;         old_val = tohost_q;    end
            ADDR_MSCRATCH:                 begin hit = 1'b1;         old_val = mscratch_q;  end
            ADDR_MCYCLE, ADDR_CYCLE:       begin hit = HAS_COUNTERS; old_val = mcycle_lo;   end
            ADDR_MCYCLEH, ADDR_CYCLEH:     begin hit = HAS_COUNTERS; old_val = mcycle_hi;   end
            ADDR_MINSTRET, ADDR_INSTRET:   begin hit = HAS_COUNTERS; old_val = minstret_lo; end
            ADDR_MINSTRETH, ADDR_INSTRETH: begin hit = HAS_COUNTERS; old_val = minstret_hi; end
            default:                       hit = 1'b0;
        endcase
    end

    assign bad     = !hit || (write_intent && is_ro_addr(addr));
    assign illegal = valid && csr_inst && bad;
    assign rd_data = (csr_inst && !bad) ? old_val : '0;
    assign commit  = valid && !stall && csr_inst && write_intent && !bad;
    assign new_val = csr_apply(op, old_val, src);

    logic wr_tohost, wr_mscratch, wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;

    assign wr_tohost    = commit && (addr == ADDR_TOHOST);
    assign wr_mscratch  = commit && (addr == ADDR_MSCRATCH);
    assign wr_mcycle    = commit && (addr == ADDR_MCYCLE);
    assign wr_mcycleh   = commit && (addr == ADDR_MCYCLEH);
    assign wr_minstret  = commit && (addr == ADDR_MINSTRET);
    assign wr_minstreth = commit && (addr == ADDR_MINSTRETH);

    generate
        if (HAS_COUNTERS) begin : g_counters
            csr_counter #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)) u_cycle (
                .clk   (clk),
                .rst   (rst),
                .inc   (1'b1),
                .wr_lo (wr_mcycle),
                .wr_hi (wr_mcycleh),
                .wdata (new_val),
                .lo    (mcycle_lo),
                .hi    (mcycle_hi)
            );
            csr_counter #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)) u_instret (
                .clk   (clk),
                .rst   (rst),
                .inc   (retire),
                .wr_lo (wr_minstret),
                .wr_hi (wr_minstreth),
                .wdata (new_val),
                .lo    (minstret_lo),
                .hi    (minstret_hi)
            );
        end else begin : g_no_counters
            assign mcycle_lo   = '0;
            assign mcycle_hi   = '0;
            assign minstret_lo = '0;
            assign minstret_hi = '0;
        end
    endgenerate

    always_comb begin
        tohost_d    = wr_tohost   ? new_val : tohost_q;
        mscratch_d  = wr_mscratch ? new_val : mscratch_q;
        tohost_wr_d = wr_tohost;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tohost_q    <= TOHOST_RST;
            mscratch_q  <= '0;
            tohost_wr_q <= 1'b0;
        end else begin
            tohost_q    <= tohost_d;
            mscratch_q  <= mscratch_d;
            tohost_wr_q <= tohost_wr_d;
        end
    end

    assign tohost    = tohost_q;
    assign tohost_wr = tohost_wr_q;

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed scenarios plus randomized traffic checked
// against an architectural model of the CSR state.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic [31:0] rs1_data;
    logic        valid, stall, retire;
    logic [31:0] rd_data, tohost;
    logic        illegal, tohost_wr;

    int errors = 0;
    int checks = 0;

    csr_file dut (
        .clk       (clk),
        .rst       (rst),
        .inst      (inst),
        .rs1_data  (rs1_data),
        .valid     (valid),
        .stall     (stall),
        .retire    (retire),
        .rd_data   (rd_data),
        .illegal   (illegal),
        .tohost    (tohost),
        .tohost_wr (tohost_wr)
    );

    always #5 clk = ~clk;

    // Architectural model state
    logic [31:0] m_tohost, m_mscratch;
    logic [63:0] m_cycle, m_instret;
    logic        m_twr;

    function automatic logic [31:0] mk(input logic [11:0] a, input logic [4:0] r, input logic [2:0] f3);
        return {a, r, f3, 5'd1, 7'h73};
    endfunction

    // {hit, value} of a CSR address in the model
    function automatic logic [32:0] m_read(input logic [11:0] a);
        case (a)
            12'h51E:          return {1'b1, m_tohost};
            12'h340:          return {1'b1, m_mscratch};
            12'hB00, 12'hC00: return {1'b1, m_cycle[31:0]};
            12'hB80, 12'hC80: return {1'b1, m_cycle[63:32]};
            12'hB02, 12'hC02: return {1'b1, m_instret[31:0]};
            12'hB82, 12'hC82: return {1'b1, m_instret[63:32]};
            default:          return 33'd0;
        endcase
    endfunction

    task automatic m_decode(output logic is_csr, output int kind, output logic [31:0] src,
                            output logic wi, output logic bad, output logic [31:0] old);
        logic [32:0] r;
        logic [2:0]  f3;
        f3     = inst[14:12];
        is_csr = (inst[6:0] == 7'h73) && (f3 != 3'd0) && (f3 != 3'd4);
        kind   = int'(f3) % 4;
        src    = (f3 >= 3'd4) ? {27'd0, inst[19:15]} : rs1_data;
        wi     = (kind == 1) || (inst[19:15] != 5'd0);
        r      = m_read(inst[31:20]);
        old    = r[31:0];
        bad    = !r[32] || (wi && inst[31:28] == 4'hC);
    endtask

    task automatic m_comb(output logic [31:0] rd, output logic ill);
        logic is_csr, wi, bad;
        int kind;
        logic [31:0] src, old;
        m_decode(is_csr, kind, src, wi, bad, old);
        rd  = (is_csr && !bad) ? old : 32'd0;
        ill = valid && is_csr && bad;
    endtask

    task automatic model_step();
        logic is_csr, wi, bad, cw, iw;
        int kind;
        logic [31:0] src, old, nv;
        if (rst) begin
            m_tohost = 32'd0; m_mscratch = 32'd0; m_cycle = 64'd0; m_instret = 64'd0; m_twr = 1'b0;
            return;
        end
        m_decode(is_csr, kind, src, wi, bad, old);
        nv = (kind == 1) ? src : (kind == 2) ? (old | src) : (old & ~src);
        cw = 1'b0; iw = 1'b0; m_twr = 1'b0;
        if (valid && !stall && is_csr && wi && !bad) begin
            case (inst[31:20])
                12'h51E: begin m_tohost = nv; m_twr = 1'b1; end
                12'h340: m_mscratch = nv;
                12'hB00: begin m_cycle[31:0]    = nv; cw = 1'b1; end
                12'hB80: begin m_cycle[63:32]   = nv; cw = 1'b1; end
                12'hB02: begin m_instret[31:0]  = nv; iw = 1'b1; end
                12'hB82: begin m_instret[63:32] = nv; iw = 1'b1; end
                default: ;
            endcase
        end
        if (!cw) m_cycle = m_cycle + 64'd1;
        if (!iw && retire) m_instret = m_instret + 64'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; stall = 1'b0; retire = 1'b0; inst = 32'd0; rs1_data = 32'd0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (tohost !== 32'd0) begin errors++; $display("FAIL reset_tohost got=%h exp=%h", tohost, 32'd0); end
        checks++; if (tohost_wr !== 1'b0) begin errors++; $display("FAIL reset_tohost_wr got=%b exp=0", tohost_wr); end
        inst = mk(12'h340, 5'd0, 3'b010); #1;
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_mscratch got=%h exp=0", rd_data); end
        inst = mk(12'hC00, 5'd0, 3'b010); #1;
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_cycle got=%h exp=0", rd_data); end
    endtask

    task automatic test_tohost();
        inst = 32'h51e51073; rs1_data = 32'd1; valid = 1'b1; #1;
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL tohost_old got=%h exp=0", rd_data); end
        tick(); valid = 1'b0;
        checks++; if (tohost !== 32'd1) begin errors++; $display("FAIL tohost_wr1 got=%h exp=1", tohost); end
        checks++; if (tohost_wr !== 1'b1) begin errors++; $display("FAIL tohost_pulse got=%b exp=1", tohost_wr); end
        tick();
        checks++; if (tohost_wr !== 1'b0) begin errors++; $display("FAIL tohost_pulse_end got=%b exp=0", tohost_wr); end
        inst = 32'h51e0d073; rs1_data = 32'd8; valid = 1'b1; #1;
        checks++; if (rd_data !== 32'd1) begin errors++; $display("FAIL tohost_rwi_old got=%h exp=1", rd_data); end
        tick(); valid = 1'b0;
        checks++; if (tohost !== 32'd1) begin errors++; $display("FAIL tohost_rwi got=%h exp=1", tohost); end
    endtask

    task automatic test_back_to_back();
        inst = mk(12'h51E, 5'd10, 3'b001); valid = 1'b1; rs1_data = 32'd2;
        tick();
        checks++; if (tohost !== 32'd2 || tohost_wr !== 1'b1) begin errors++; $display("FAIL b2b_first got=%h/%b exp=2/1", tohost, tohost_wr); end
        rs1_data = 32'd3;
        tick(); valid = 1'b0;
        checks++; if (tohost !== 32'd3 || tohost_wr !== 1'b1) begin errors++; $display("FAIL b2b_second got=%h/%b exp=3/1", tohost, tohost_wr); end
        tick();
        checks++; if (tohost_wr !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b exp=0", tohost_wr); end
    endtask

    task automatic test_mscratch();
        inst = mk(12'h340, 5'd10, 3'b010); rs1_data = 32'h0F; valid = 1'b1;
        tick(); valid = 1'b0; inst = mk(12'h340, 5'd0, 3'b010); #1;
        checks++; if (rd_data !== 32'h0F) begin errors++; $display("FAIL mscratch_rs got=%h exp=0f", rd_data); end
        inst = mk(12'h340, 5'd10, 3'b011); rs1_data = 32'h05; valid = 1'b1;
        tick(); valid = 1'b0; inst = mk(12'h340, 5'd0, 3'b010); #1;
        checks++; if (rd_data !== 32'h0A) begin errors++; $display("FAIL mscratch_rc got=%h exp=0a", rd_data); end
        rs1_data = 32'hFF; valid = 1'b1; #1;
        checks++; if (rd_data !== 32'h0A) begin errors++; $display("FAIL mscratch_rs_x0 got=%h exp=0a", rd_data); end
        tick(); valid = 1'b0; #1;
        checks++; if (rd_data !== 32'h0A) begin errors++; $display("FAIL mscratch_nowrite got=%h exp=0a", rd_data); end
    endtask

    task automatic test_stall();
        inst = mk(12'h51E, 5'd10, 3'b001); rs1_data = 32'd5; valid = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (tohost !== 32'd3 || tohost_wr !== 1'b0) begin errors++; $display("FAIL stall_hold%0d got=%h/%b exp=3/0", i, tohost, tohost_wr); end
        end
        stall = 1'b0;
        tick(); valid = 1'b0; rs1_data = 32'd6;
        checks++; if (tohost !== 32'd5 || tohost_wr !== 1'b1) begin errors++; $display("FAIL stall_release got=%h/%b exp=5/1", tohost, tohost_wr); end
        tick();
        checks++; if (tohost !== 32'd5 || tohost_wr !== 1'b0) begin errors++; $display("FAIL invalid_nochange got=%h/%b exp=5/0", tohost, tohost_wr); end
    endtask

    task automatic test_counters();
        valid = 1'b1; rs1_data = 32'hFFFF_FFFF;
        inst = mk(12'hB00, 5'd10, 3'b001); tick();
        inst = mk(12'hB80, 5'd10, 3'b001); tick();
        valid = 1'b0; tick();
        inst = mk(12'hC00, 5'd0, 3'b010); #1;
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL cycle_wrap_lo got=%h exp=0", rd_data); end
        inst = mk(12'hC80, 5'd0, 3'b010); #1;
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL cycle_wrap_hi got=%h exp=0", rd_data); end
        inst = mk(12'hB00, 5'd10, 3'b001); rs1_data = 32'd100; valid = 1'b1;
        tick(); valid = 1'b0; inst = mk(12'hC00, 5'd0, 3'b010); #1;
        checks++; if (rd_data !== 32'd100) begin errors++; $display("FAIL cycle_write got=%0d exp=100", rd_data); end
        tick();
        checks++; if (rd_data !== 32'd101) begin errors++; $display("FAIL cycle_next got=%0d exp=101", rd_data); end
        rs1_data = 32'd0; valid = 1'b1;
        inst = mk(12'hB02, 5'd10, 3'b001); tick();
        inst = mk(12'hB82, 5'd10, 3'b001); tick();
        valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            retire = (i % 2 == 1);
            tick();
        end
        retire = 1'b0; inst = mk(12'hC02, 5'd0, 3'b010); #1;
        checks++; if (rd_data !== 32'd7) begin errors++; $display("FAIL instret_count got=%0d exp=7", rd_data); end
        inst = mk(12'hC82, 5'd0, 3'b010); #1;
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL instret_hi got=%0d exp=0", rd_data); end
        inst = mk(12'hB02, 5'd10, 3'b001); rs1_data = 32'd50; valid = 1'b1; retire = 1'b1;
        tick(); valid = 1'b0; retire = 1'b0; inst = mk(12'hC02, 5'd0, 3'b010); #1;
        checks++; if (rd_data !== 32'd50) begin errors++; $display("FAIL instret_write_prio got=%0d exp=50", rd_data); end
    endtask

    task automatic test_illegal();
        inst = mk(12'hC00, 5'd10, 3'b001); rs1_data = 32'd3; valid = 1'b1; #1;
        checks++; if (illegal !== 1'b1 || rd_data !== 32'd0) begin errors++; $display("FAIL ill_ro_write got=%b/%h exp=1/0", illegal, rd_data); end
        tick();
        inst = mk(12'hC00, 5'd0, 3'b010); rs1_data = 32'hFF; #1;
        checks++; if (illegal !== 1'b0 || rd_data !== m_cycle[31:0]) begin errors++; $display("FAIL ill_ro_read got=%b/%h exp=0/%h", illegal, rd_data, m_cycle[31:0]); end
        inst = mk(12'h7C0, 5'd10, 3'b001); #1;
        checks++; if (illegal !== 1'b1 || rd_data !== 32'd0) begin errors++; $display("FAIL ill_unimpl got=%b/%h exp=1/0", illegal, rd_data); end
        valid = 1'b0; #1;
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_not_valid got=%b exp=0", illegal); end
        tick();
    endtask

    task automatic test_reset_mid();
        inst = mk(12'h51E, 5'd10, 3'b001); rs1_data = 32'd9; valid = 1'b1; retire = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; valid = 1'b0; retire = 1'b0;
        checks++; if (tohost !== 32'd0 || tohost_wr !== 1'b0) begin errors++; $display("FAIL rstmid_tohost got=%h/%b exp=0/0", tohost, tohost_wr); end
        inst = mk(12'hC02, 5'd0, 3'b010); #1;
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL rstmid_instret got=%h exp=0", rd_data); end
        tick();
        checks++; if (tohost_wr !== 1'b0) begin errors++; $display("FAIL rstmid_pulse got=%b exp=0", tohost_wr); end
    endtask

    task automatic test_random();
        logic [11:0] pool [12] = '{12'h51E, 12'h340, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                   12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7C0, 12'h123};
        logic [31:0] erd;
        logic        eill;
        logic [4:0]  r;
        for (int i = 0; i < 400; i++) begin
            r    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            inst = {pool[$urandom_range(0, 11)], r, 3'($urandom_range(0, 7)), 5'd3,
                    ($urandom_range(0, 7) == 0) ? 7'h33 : 7'h73};
            rs1_data = $urandom;
            valid    = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 3) == 0);
            retire   = ($urandom_range(0, 1) == 1);
            rst      = ($urandom_range(0, 60) == 0);
            #1;
            m_comb(erd, eill);
            checks++; if (rd_data !== erd) begin errors++; $display("FAIL rand_rd[%0d] inst=%h got=%h exp=%h", i, inst, rd_data, erd); end
            checks++; if (illegal !== eill) begin errors++; $display("FAIL rand_ill[%0d] inst=%h got=%b exp=%b", i, inst, illegal, eill); end
            tick();
            checks++; if (tohost !== m_tohost || tohost_wr !== m_twr) begin errors++; $display("FAIL rand_tohost[%0d] got=%h/%b exp=%h/%b", i, tohost, tohost_wr, m_tohost, m_twr); end
        end
        rst = 1'b0; valid = 1'b0; stall = 1'b0; retire = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tohost();
        test_back_to_back();
        test_mscratch();
        test_stall();
        test_counters();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Parametrised Zicsr register file for the RV32 core. Generalises the single-register tohost CSR unit to a small set of machine CSRs plus 64-bit cycle/instret counters.
- Supports all six CSR instruction forms: rw/rs/rc, each in register and immediate variants.
- Sits in the execute/memory stage.
- Returns the old CSR value for writeback and commits the write on the clock edge when the instruction is allowed to advance.

Parameters:
- XLEN, 32, data width of CSR registers and rs1 operand.
- CNT_WIDTH, 64, counter width; must be >XLEN and <=2*XLEN; upper bits read through the *h CSRs.
- HAS_COUNTERS, 1, 0 removes the cycle/instret counters; their addresses then decode as illegal.
- TOHOST_RST, 0, reset value of tohost.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- inst  in  32  instruction in this stage; opcode[6:0], funct3[14:12], rs1/uimm[19:15], csr addr[31:20]
- rs1_data  in  XLEN  forwarded rs1 value
- valid  in  1  inst is a real (non-bubble) instruction
- stall  in  1  stage held this cycle; no CSR side effects
- retire  in  1  one instruction retires this cycle (increments instret)
- rd_data  out  XLEN  combinational old value of addressed CSR (0 if not a CSR inst or illegal)
- illegal  out  1  combinational; valid CSR inst targeting unimplemented address or writing a read-only CSR
- tohost  out  XLEN  registered tohost (0x51E) value
- tohost_wr  out  1  registered one-cycle pulse after any commit to tohost

Behaviour:
- Decode:
  - CSR inst when opcode==7'h73 and funct3!=0.
  - funct3 001/010/011 = rw/rs/rc with src=rs1_data.
  - funct3 101/110/111 = rwi/rsi/rci with src=zero-extended uimm.
  - funct3 100 is not a CSR inst.
- Implemented addresses:
  - 0x51E tohost, RW.
  - 0x340 mscratch, RW.
  - 0xB00/0xB80 mcycle/mcycleh, RW.
  - 0xB02/0xB82 minstret/minstreth, RW.
  - 0xC00/0xC80 cycle/cycleh, RO aliases.
  - 0xC02/0xC82 instret/instreth, RO aliases.
  - *h addresses return bits [CNT_WIDTH-1:XLEN], zero-extended.
- Write intent:
  - rw/rwi always write.
  - rs/rc and rsi/rci write only when rs1 field / uimm != 0.
- New value:
  - rw: src.
  - rs: old|src.
  - rc: old&~src.
- Commit: commit = valid & ~stall & csr_inst & write_intent & ~illegal. The register updates on the rising clk edge of that cycle; read-after-write in the next cycle sees the new value.
- Read: rd_data valid same cycle, independent of stall; reads have no side effects.
- illegal:
  - Asserted for an unimplemented address, or write_intent to a 0xCxx address.
  - No state changes; rd_data forced to 0.
- Counters:
  - cycle increments by 1 every clk with rst low, including stall cycles.
  - instret increments by 1 when retire is high.
  - Both wrap 2^CNT_WIDTH-1 -> 0.
- Counter write priority: a commit to the low or high half of a counter replaces that half. That counter does not increment in the same cycle; the other counter is unaffected.
- tohost_wr: 1 in the cycle after a tohost commit, otherwise 0. Back-to-back commits give a continuous high.
- Reset (rst=1 at an edge):
  - tohost=TOHOST_RST, mscratch=0, counters=0, tohost_wr=0.
  - Reset dominates a simultaneous commit and increment.
  - An instruction presented during reset has no effect.
- Combinational outputs (rd_data, illegal) follow inputs even during reset.

Decomposition:
- csr_pkg holds:
  - CSR address localparams: ADDR_TOHOST, ADDR_MSCRATCH, ADDR_MCYCLE(H), ADDR_MINSTRET(H), ADDR_CYCLE(H), ADDR_INSTRET(H).
  - OPC_SYSTEM.
  - funct3 encodings.
  - The op enum {CSR_RW, CSR_RS, CSR_RC}.
- One sub-module, csr_counter: parametrised CNT_WIDTH/XLEN. Inputs: inc, wr_lo, wr_hi, wdata. Outputs: lo, hi. Write-over-increment priority and wrap are implemented here. Instantiated twice when HAS_COUNTERS=1.

Test Plan:
- Reset, then inst=32'h51e51073 (csrrw x0,0x51E,x10), rs1_data=1, valid=1 for one cycle -> next cycle tohost=1, tohost_wr=1 for one cycle. Then inst=32'h51e0d073 (csrrwi, uimm=1), rs1_data=8 -> tohost stays 1 and rd_data=1 during the cycle.
- csrrs on mscratch with rs1_data=0x0F, then csrrc with rs1_data=0x05 -> mscratch 0x0F then 0x0A. Repeat csrrs with rs1 field=x0 and rs1_data=0xFF -> no write; rd_data=0x0A.
- Stall: csrrw tohost with rs1_data=5, valid=1, stall=1 for 3 cycles, then stall=0 -> tohost written exactly once to 5 after stall drops. valid=0 with identical inst -> no change.
- Counter wrap/priority:
  - Write mcycle=0xFFFFFFFF and mcycleh=0xFFFFFFFF; after 1 free cycle cycle reads 0/0.
  - csrrw mcycle=100 -> next-cycle read gives 100 (no +1 in the write cycle), 101 one cycle later.
  - instret counts only retire pulses: 7 pulses -> instret=7.
- Illegal: csrrw to 0xC00 with rs1_data=3 -> illegal=1, rd_data=0, cycle unchanged. csrrs 0xC00 with rs1=x0 -> illegal=0, rd_data=current cycle. csrrw to 0x7C0 -> illegal=1.
- Reset mid-operation: assert rst for 1 cycle while committing tohost=9 with retire=1 -> tohost=0, instret=0, tohost_wr=0 afterwards.
